// File: rtl/seg7_scan_driver_pkg.sv
// seg7_scan_driver_pkg: shared constants, FSM states and hex segment table for the 7-segment scan driver
package seg7_scan_driver_pkg;
   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [3:0] AN_OFF = 4'hF;
   typedef enum logic {ST_GUARD, ST_SHOW} state_t;
   // active-low {g,f,e,d,c,b,a}, indexed by hex value
   localparam logic [6:0] SEG_HEX [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };
endpackage

// File: rtl/seg7_scan_driver_if.sv
// seg7_scan_driver_if: digit data in, multiplexed segment/anode drive out
interface seg7_scan_driver_if;
   logic [15:0] din;
   logic [3:0] dp_in;
   logic [3:0] blank;
   logic [6:0] seg;
   logic dp;
   logic [3:0] an;
   logic frame_tick;
   modport master(output din, dp_in, blank, input seg, dp, an, frame_tick);
   modport slave(input din, dp_in, blank, output seg, dp, an, frame_tick);
endinterface

// File: rtl/seg7_decoder.sv
// seg7_decoder: combinational hex to active-low 7-segment lookup
module seg7_decoder
   import seg7_scan_driver_pkg::*;
(
   input  logic [3:0] hex,
   output logic [6:0] seg
);
   always_comb seg = SEG_HEX[hex];
endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: 4-digit common-anode scan with guard interval and per-frame input shadowing
module seg7_scan_driver
   import seg7_scan_driver_pkg::*;
#(
   parameter int REFRESH_DIV = 50000,
   parameter int GUARD_CYCLES = 16
) (
   input logic clk,
   input logic rst,
   seg7_scan_driver_if.slave bus
);
   localparam int MAXN = REFRESH_DIV > GUARD_CYCLES ? (REFRESH_DIV > 2 ? REFRESH_DIV : 2)
                                                    : (GUARD_CYCLES > 2 ? GUARD_CYCLES : 2);
   localparam int CW = $clog2(MAXN);
   localparam logic [CW-1:0] R_LAST = CW'(REFRESH_DIV - 1);
   localparam logic [CW-1:0] G_LAST = CW'(GUARD_CYCLES > 0 ? GUARD_CYCLES - 1 : 0);
   state_t state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [1:0] idx, idx_n;
   logic [15:0] sh_din, src_din;
   logic [3:0] sh_dp, sh_blank, src_dp, src_blank;
   logic slot_end, load, lit;
   logic [6:0] dec;
   // outputs are computed for the state being entered, so the first SHOW cycle of digit 0 already uses fresh inputs
   always_comb begin
      slot_end = state == ST_SHOW ? cnt == R_LAST : (GUARD_CYCLES == 0 || cnt == G_LAST);
      state_n = slot_end ? ((state == ST_SHOW && GUARD_CYCLES > 0) ? ST_GUARD : ST_SHOW) : state;
      idx_n = (slot_end && state == ST_SHOW) ? idx + 2'd1 : idx;
      cnt_n = slot_end ? '0 : cnt + CW'(1);
      load = slot_end && state_n == ST_SHOW && idx_n == 2'd0;
      src_din = load ? bus.din : sh_din;
      src_dp = load ? bus.dp_in : sh_dp;
      src_blank = load ? bus.blank : sh_blank;
      lit = state_n == ST_SHOW && !src_blank[idx_n];
   end
   seg7_decoder u_dec (
      .hex(src_din[{idx_n, 2'b00} +: 4]),
      .seg(dec)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_GUARD;
         cnt <= '0;
         idx <= '0;
         sh_din <= '0;
         sh_dp <= '0;
         sh_blank <= '0;
         bus.an <= AN_OFF;
         bus.seg <= SEG_BLANK;
         bus.dp <= 1'b1;
         bus.frame_tick <= 1'b0;
      end else begin
         state <= state_n;
         cnt <= cnt_n;
         idx <= idx_n;
         if (load) begin
            sh_din <= bus.din;
            sh_dp <= bus.dp_in;
            sh_blank <= bus.blank;
         end
         bus.an <= lit ? ~(4'b0001 << idx_n) : AN_OFF;
         bus.seg <= lit ? dec : SEG_BLANK;
         bus.dp <= ~(lit & src_dp[idx_n]);
         bus.frame_tick <= load;
      end
   end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: frame-position model checked every cycle, plus literal spot checks
module tb_seg7_scan_driver;
   localparam int R = 4;
   localparam int G = 1;
   localparam int S = R + G;
   localparam int F = 4 * S;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int total = 0;
   int bad = 0;
   seg7_scan_driver_if bus ();
   seg7_scan_driver #(.REFRESH_DIV(R), .GUARD_CYCLES(G)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   logic [6:0] dec_tbl [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };
   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h at %0t", name, act, exp, $time);
      end
   endtask
   // model: position pm counts non-reset edges; each frame is 4 slots of R lit cycles then G dark
   int pm = 0;
   logic valid = 1'b0;
   logic [15:0] m_din;
   logic [3:0] m_dp, m_blank;
   logic [3:0] e_an;
   logic [6:0] e_seg;
   logic e_dp, e_ft;
   always @(posedge clk) begin
      int q, slot;
      logic on;
      valid <= 1'b1;
      if (rst) begin
         pm <= 0;
         e_an <= 4'hF;
         e_seg <= 7'h7F;
         e_dp <= 1'b1;
         e_ft <= 1'b0;
      end else begin
         q = pm % F;
         if (q == 0) begin
            m_din = bus.din;
            m_dp = bus.dp_in;
            m_blank = bus.blank;
         end
         slot = q / S;
         on = (q % S) < R && !m_blank[slot];
         e_an <= on ? ~(4'b0001 << slot) : 4'hF;
         e_seg <= on ? dec_tbl[(m_din >> (4 * slot)) & 16'hF] : 7'h7F;
         e_dp <= !(on && m_dp[slot]);
         e_ft <= q == 0;
         pm <= pm + 1;
      end
   end
   always @(negedge clk) begin
      if (valid) begin
         chk("an", {12'h0, bus.an}, {12'h0, e_an});
         chk("seg", {9'h0, bus.seg}, {9'h0, e_seg});
         chk("dp", {15'h0, bus.dp}, {15'h0, e_dp});
         chk("frame_tick", {15'h0, bus.frame_tick}, {15'h0, e_ft});
         chk("an_single_low", {15'h0, $countones(~bus.an) <= 1}, 16'h1);
         assert ($countones(~bus.an) <= 1) else $error("two anodes low: %b", bus.an);
      end
   end
   task automatic at(input int k);
      int n = 0;
      @(negedge clk);
      while (pm != k + 1 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      if (pm != k + 1) chk("wait_timeout", pm[15:0], 16'(k + 1));
   endtask
   initial begin
      bus.din = 16'hFFFF;
      bus.dp_in = 4'hF;
      bus.blank = 4'h0;
      repeat (3) @(negedge clk);
      chk("rst_an", {12'h0, bus.an}, 16'h000F);
      chk("rst_seg", {9'h0, bus.seg}, 16'h007F);
      chk("rst_ft", {15'h0, bus.frame_tick}, 16'h0);
      bus.din = 16'h1234;
      bus.dp_in = 4'h0;
      rst = 1'b0;
      at(0);
      chk("t2_ft", {15'h0, bus.frame_tick}, 16'h1);
      chk("t2_an0", {12'h0, bus.an}, 16'h000E);
      chk("t2_seg0", {9'h0, bus.seg}, 16'h0019);
      at(3);
      chk("t2_an0_last", {12'h0, bus.an}, 16'h000E);
      at(4);
      chk("t2_guard", {12'h0, bus.an}, 16'h000F);
      at(5);
      chk("t2_an1", {12'h0, bus.an}, 16'h000D);
      chk("t2_seg1", {9'h0, bus.seg}, 16'h0030);
      at(6);
      bus.din = 16'hABCD;
      at(10);
      chk("t3_an2", {12'h0, bus.an}, 16'h000B);
      chk("t3_seg2", {9'h0, bus.seg}, 16'h0024);
      at(15);
      chk("t3_seg3", {9'h0, bus.seg}, 16'h0079);
      at(20);
      chk("t3_ft", {15'h0, bus.frame_tick}, 16'h1);
      chk("t3_seg_d", {9'h0, bus.seg}, 16'h0021);
      at(21);
      bus.blank = 4'b0010;
      bus.dp_in = 4'b0100;
      at(40);
      chk("t4_dp0", {15'h0, bus.dp}, 16'h1);
      at(45);
      chk("t4_blank_an", {12'h0, bus.an}, 16'h000F);
      at(50);
      chk("t4_an2", {12'h0, bus.an}, 16'h000B);
      chk("t4_dp2", {15'h0, bus.dp}, 16'h0);
      at(52);
      rst = 1'b1;
      bus.blank = 4'h0;
      bus.dp_in = 4'h0;
      bus.din = 16'h0000;
      @(negedge clk);
      chk("t5_rst_an", {12'h0, bus.an}, 16'h000F);
      chk("t5_rst_ft", {15'h0, bus.frame_tick}, 16'h0);
      rst = 1'b0;
      at(0);
      chk("t5_ft", {15'h0, bus.frame_tick}, 16'h1);
      chk("t5_an0", {12'h0, bus.an}, 16'h000E);
      chk("t5_seg0", {9'h0, bus.seg}, 16'h0040);
      for (int v = 1; v < 16; v++) begin
         at(20 * v - 3);
         bus.din = 16'(v);
         at(20 * v);
         chk("t6_sweep_an", {12'h0, bus.an}, 16'h000E);
      end
      chk("t6_seg_f", {9'h0, bus.seg}, 16'h000E);
      at(305);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
